// File: rtl/nv_nvdla_pdp_rd_pkg.sv
// nv_nvdla_pdp_rd_pkg: shared field widths, request/response payload structs,
// FSM state encoding and small helpers for the PDP read responder.
package nv_nvdla_pdp_rd_pkg;

    localparam int ADDR_W = 64;
    localparam int SIZE_W = 15;
    localparam int DATA_W = 512;
    localparam int MASK_W = 2;
    localparam int BEAT_W = ADDR_W - 6;   // 64B beat index
    localparam int ATOM_W = 16;           // atoms left, holds size+1
    localparam int HALF_W = DATA_W / 2;   // one 32B atom
    localparam int REQ_W  = SIZE_W + ADDR_W;
    localparam int RSP_W  = MASK_W + DATA_W;

    typedef struct packed {
        logic [SIZE_W-1:0] size;   // 32B atoms minus 1
        logic [ADDR_W-1:0] addr;   // byte address, 32B aligned
    } rd_req_pd_t;

    typedef struct packed {
        logic [MASK_W-1:0] mask;   // bit0 = low 32B, bit1 = high 32B
        logic [DATA_W-1:0] data;
    } rd_rsp_pd_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } rd_state_t;

    // Number of atoms a beat mask carries.
    function automatic logic [1:0] mask_atoms(input logic [MASK_W-1:0] mask);
        return {1'b0, mask[0]} + {1'b0, mask[1]};
    endfunction

    // Force the 32B halves that the mask does not select to zero.
    function automatic logic [DATA_W-1:0] mask_data(input logic [MASK_W-1:0] mask,
                                                    input logic [DATA_W-1:0] data);
        logic [DATA_W-1:0] d;
        d = data;
        if (!mask[0]) d[HALF_W-1:0] = '0;
        if (!mask[1]) d[DATA_W-1:HALF_W] = '0;
        return d;
    endfunction

endpackage

// File: rtl/nv_nvdla_pdp_rd_responder_if.sv
// nv_nvdla_pdp_rd_responder_if: client request/response channels, credit
// return and the 64B backing-store read port of the PDP read responder.
interface nv_nvdla_pdp_rd_responder_if;
    import nv_nvdla_pdp_rd_pkg::*;

    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [REQ_W-1:0]  rd_req_pd;
    logic              rd_rsp_valid;
    logic              rd_rsp_ready;
    logic [RSP_W-1:0]  rd_rsp_pd;
    logic              rd_cdt_lat_fifo_pop;
    logic              mem_rd_valid;
    logic              mem_rd_ready;
    logic [BEAT_W-1:0] mem_rd_addr;
    logic              mem_rd_rsp_valid;
    logic              mem_rd_rsp_ready;
    logic [DATA_W-1:0] mem_rd_rsp_data;

    // Responder side.
    modport slave (
        input  rd_req_valid, rd_req_pd, rd_rsp_ready, rd_cdt_lat_fifo_pop,
               mem_rd_ready, mem_rd_rsp_valid, mem_rd_rsp_data,
        output rd_req_ready, rd_rsp_valid, rd_rsp_pd, mem_rd_valid,
               mem_rd_addr, mem_rd_rsp_ready
    );

    // Client and backing-store side.
    modport master (
        output rd_req_valid, rd_req_pd, rd_rsp_ready, rd_cdt_lat_fifo_pop,
               mem_rd_ready, mem_rd_rsp_valid, mem_rd_rsp_data,
        input  rd_req_ready, rd_rsp_valid, rd_rsp_pd, mem_rd_valid,
               mem_rd_addr, mem_rd_rsp_ready
    );

endinterface

// File: rtl/nv_nvdla_pdp_rd_mask_fifo.sv
// nv_nvdla_pdp_rd_mask_fifo: small synchronous FIFO holding the beat mask of
// every issued beat until its data returns. Head is visible combinationally.
module nv_nvdla_pdp_rd_mask_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [OCC_W-1:0] count;
    logic             do_push, do_pop;

    assign full    = (count == OCC_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage write.
    // NOTE: the array has no reset; an entry is only read after count shows it was written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // Pointers and occupancy.
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nv_nvdla_pdp_rd_responder.sv
// nv_nvdla_pdp_rd_responder: memory-side responder for the PDP read DMA.
// Splits 32B-atom read requests into 64B beats, issues them under a credit
// counter that mirrors the client latency FIFO, and returns masked data
// through a registered valid/ready stage.
// Optional build macro NV_NVDLA_PDP_RD_RSP_PERF_EN adds the rd_stall_cnt output.
module nv_nvdla_pdp_rd_responder
    import nv_nvdla_pdp_rd_pkg::*;
#(
    parameter int LAT_FIFO_DEPTH = 8,
    parameter int CNT_W          = 4
) (
    input  logic nvdla_core_clk,
    input  logic nvdla_core_rst,
`ifdef NV_NVDLA_PDP_RD_RSP_PERF_EN
    output logic [31:0] rd_stall_cnt,
`endif
    nv_nvdla_pdp_rd_responder_if.slave bus
);
    localparam logic [CNT_W-1:0] CDT_MAX = CNT_W'(LAT_FIFO_DEPTH);

    rd_state_t         state, next_state;
    rd_req_pd_t        req;
    rd_rsp_pd_t        rsp_pd_q;
    logic              rsp_valid_q;
    logic              run_q;
    logic [BEAT_W-1:0] beat_addr;
    logic              half;
    logic [ATOM_W-1:0] atoms_left, atoms_after;
    logic [CNT_W-1:0]  credits;
    logic [MASK_W-1:0] beat_mask, fifo_head;
    logic              accept, issue, cdt_inc, rsp_take;
    logic              fifo_full, fifo_empty;
    logic              unused_addr_lsb;

    assign req             = rd_req_pd_t'(bus.rd_req_pd);
    assign unused_addr_lsb = ^req.addr[4:0];

    // run_q keeps the handshake readies low while reset is held.
    assign bus.rd_req_ready     = run_q && (state == ST_IDLE);
    assign bus.mem_rd_valid     = (state == ST_ISSUE) && (credits != '0) && !fifo_full;
    assign bus.mem_rd_addr      = beat_addr;
    assign bus.mem_rd_rsp_ready = run_q && (!rsp_valid_q || bus.rd_rsp_ready);
    assign bus.rd_rsp_valid     = rsp_valid_q;
    assign bus.rd_rsp_pd        = rsp_pd_q;

    assign accept   = bus.rd_req_valid && bus.rd_req_ready;
    assign issue    = bus.mem_rd_valid && bus.mem_rd_ready;
    assign cdt_inc  = bus.rd_cdt_lat_fifo_pop && (credits != CDT_MAX);
    assign rsp_take = bus.mem_rd_rsp_valid && bus.mem_rd_rsp_ready && !fifo_empty;

    // A beat starting on an odd atom carries only the high half; otherwise
    // it takes two atoms when at least two remain.
    assign beat_mask   = {half || (atoms_left >= ATOM_W'(2)), !half};
    assign atoms_after = atoms_left - ATOM_W'(mask_atoms(beat_mask));

    // State register and post-reset enable.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state <= ST_IDLE;
            run_q <= 1'b0;
        end else begin
            state <= next_state;
            run_q <= 1'b1;
        end
    end

    // Next-state: leave IDLE on accept, return once the last atom issues.
    // NOTE: next_state gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (accept) next_state = ST_ISSUE;
            ST_ISSUE: if (issue && (atoms_after == '0)) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Beat walker: latch the request, then advance one beat per issue.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            beat_addr  <= '0;
            half       <= 1'b0;
            atoms_left <= '0;
        end else if (accept) begin
            beat_addr  <= req.addr[ADDR_W-1:6];
            half       <= req.addr[5];
            atoms_left <= {1'b0, req.size} + ATOM_W'(1);
        end else if (issue) begin
            beat_addr  <= beat_addr + 1'b1;
            half       <= 1'b0;
            atoms_left <= atoms_after;
        end
    end

    // Credit counter: +1 per returned credit (saturating), -1 per issued beat.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            credits <= CDT_MAX;
        end else begin
            case ({cdt_inc, issue})
                2'b10:   credits <= credits + 1'b1;
                2'b01:   credits <= credits - 1'b1;
                default: credits <= credits;
            endcase
        end
    end

    // Response output register: load masked data with its beat mask.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            rsp_valid_q <= 1'b0;
            rsp_pd_q    <= '0;
        end else if (rsp_take) begin
            rsp_valid_q   <= 1'b1;
            rsp_pd_q.mask <= fifo_head;
            rsp_pd_q.data <= mask_data(fifo_head, bus.mem_rd_rsp_data);
        end else if (bus.rd_rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    nv_nvdla_pdp_rd_mask_fifo #(
        .DEPTH (LAT_FIFO_DEPTH),
        .WIDTH (MASK_W)
    ) u_mask_fifo (
        .clk     (nvdla_core_clk),
        .rst     (nvdla_core_rst),
        .push    (issue),
        .wr_data (beat_mask),
        .pop     (rsp_take),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

`ifdef NV_NVDLA_PDP_RD_RSP_PERF_EN
    // Saturating count of ISSUE cycles blocked by credits or the memory port.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            rd_stall_cnt <= '0;
        end else if ((state == ST_ISSUE) && ((credits == '0) || !bus.mem_rd_ready)
                     && (rd_stall_cnt != 32'hFFFF_FFFF)) begin
            rd_stall_cnt <= rd_stall_cnt + 32'd1;
        end
    end
`endif

    // Client must not return more credits than it holds.
    a_cdt_overflow: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
        !(bus.rd_cdt_lat_fifo_pop && (credits == CDT_MAX)));

    // Memory data must match an issued beat; otherwise it is dropped.
    a_rsp_no_beat: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
        !(bus.mem_rd_rsp_valid && bus.mem_rd_rsp_ready && fifo_empty));

endmodule

// File: doc/nv_nvdla_pdp_rd_responder.md
Name: nv_nvdla_pdp_rd_responder

Overview:
- Memory-side responder for the PDP RDMA read-DMA interface. It accepts 79-bit read requests {size[14:0], addr[63:0]} and splits each one into 64B beats.
- Beats are issued in order to a 64B-wide backing-store read port. Data returns as 514-bit responses {mask[1:0], data[511:0]}.
- Issue is throttled by a credit counter that models the client latency FIFO. The client returns a credit on each lat_fifo_pop.
- Used as the MCIF/CVIF-side counterpart in subsystem benches and in the memory-interface arbiter path.

Parameters:
- LAT_FIFO_DEPTH, 8, number of client latency-FIFO entries. Also the initial credit count and the internal mask-FIFO depth.
- CNT_W, 4, credit-counter width, equal to clog2(LAT_FIFO_DEPTH+1).

Ports:
- nvdla_core_clk  in  1  core clock
- nvdla_core_rst  in  1  asynchronous, active-high reset
- rd_req_valid  in  1  request valid
- rd_req_ready  out  1  request accept
- rd_req_pd  in  79  [63:0] byte address, 32B aligned; [78:64] size in 32B atoms minus 1
- rd_rsp_valid  out  1  response valid
- rd_rsp_ready  in  1  response accept
- rd_rsp_pd  out  514  [511:0] data; [513:512] mask (bit0 = low 32B, bit1 = high 32B)
- rd_cdt_lat_fifo_pop  in  1  one credit returned per cycle high
- mem_rd_valid  out  1  beat read request
- mem_rd_ready  in  1  beat read accept
- mem_rd_addr  out  58  beat address, equal to byte addr[63:6]
- mem_rd_rsp_valid  in  1  beat data valid, returned in order
- mem_rd_rsp_ready  out  1  beat data accept
- mem_rd_rsp_data  in  512  beat data

Behaviour:
- Reset state:
  - Outputs: rd_req_ready=0, rd_rsp_valid=0, rd_rsp_pd=0, mem_rd_valid=0, mem_rd_addr=0, mem_rd_rsp_ready=0.
  - Credits = LAT_FIFO_DEPTH; mask FIFO empty; FSM in IDLE.
  - A reset asserted mid-operation drops all in-flight beats and restores this state. No partial response is emitted after reset deasserts.
- FSM states: IDLE, ISSUE.
- IDLE:
  - rd_req_ready=1.
  - On rd_req_valid&&rd_req_ready, latch beat_addr=addr[63:6], half=addr[5], atoms_left=size+1 (16-bit), then go to ISSUE. The request is accepted with one cycle of latency.
- ISSUE:
  - rd_req_ready=0.
  - mem_rd_valid = (credits!=0) && !mask_fifo_full.
  - Beat mask:
    - low bit = !half;
    - high bit = (half || atoms_left>=2);
    - popcount(mask) is taken against atoms_left (first beat with half=1 uses a single atom).
  - On mem_rd_valid&&mem_rd_ready:
    - push mask to the mask FIFO;
    - decrement credits;
    - atoms_left -= popcount(mask);
    - half=0; beat_addr+=1.
  - When atoms_left reaches 0 the FSM returns to IDLE in the same cycle. The next request can be accepted the following cycle.
- Beat-count examples:
  - addr[5]=0, size=0 -> 1 beat, mask 01.
  - addr[5]=1, size=0 -> 1 beat, mask 10.
  - addr[5]=1, size=2 -> 2 beats, masks 10 then 11.
  - addr[5]=0, size=2 -> 2 beats, masks 11 then 01.
- beat_addr wraps modulo 2^58 with no error.
- Return path:
  - Output register stage with valid/ready.
  - mem_rd_rsp_ready = !rd_rsp_valid || rd_rsp_ready.
  - On mem_rd_rsp_valid&&mem_rd_rsp_ready: load rd_rsp_pd={mask_fifo_head, data with unmasked 256-bit halves forced to 0}, pop the mask FIFO, set rd_rsp_valid.
  - Latency: mem response to rd_rsp_valid is 1 cycle. Full throughput is maintained under continuous ready.
- Credits:
  - +1 on rd_cdt_lat_fifo_pop, -1 on beat issue; both in the same cycle gives net 0.
  - A pop while credits==LAT_FIFO_DEPTH is ignored (saturate) and flagged by assertion.
  - credits==0 stalls ISSUE until the next pop.
- Mask FIFO:
  - Depth LAT_FIFO_DEPTH; it can never overflow while credits hold.
  - mem_rd_rsp_valid while the FIFO is empty is an error: assertion fires and the beat is dropped.

Optional Feature:
- Macro: NV_NVDLA_PDP_RD_RSP_PERF_EN.
- Defined: adds output rd_stall_cnt[31:0], cleared by reset.
  - Increments each cycle the FSM is in ISSUE with credits==0 or mem_rd_ready==0.
  - Saturates at 32'hFFFF_FFFF.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package nv_nvdla_pdp_rd_pkg:
  - field widths: ADDR_W=64, SIZE_W=15, DATA_W=512, MASK_W=2;
  - request/response pd struct typedefs;
  - FSM state enum.
- One sub-module, nv_nvdla_pdp_rd_mask_fifo: parameterised sync FIFO, 2 bits wide, with full/empty flags.

Test Plan:
- Single request addr=0x1000, size=0 -> one mem beat at addr 0x40; response mask=01 with upper 256 bits zero.
- addr=0x1020, size=4 (5 atoms) -> 3 beats at 0x40,0x41,0x42 with masks 10,11,11; 3 responses in order.
- LAT_FIFO_DEPTH=8, no pops, size=31 at addr 0 (16 beats) -> exactly 8 beats issued, then stall. Each pop then releases exactly one beat; completion after 8 pops.
- Pop and issue in the same cycle with credits=3 -> credits remain 3.
- Hold rd_rsp_ready=0 for 10 cycles mid-burst -> mem_rd_rsp_ready drops, no data lost, order preserved.
- Reset asserted with 4 beats outstanding -> all outputs 0 immediately. After release, credits=8 and a fresh request completes normally.
